// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encodings and gain-compensation constants shared by the CORDIC core and its output stage
package cordic_pkg;
  typedef enum logic [1:0] {LINEAR = 2'b00, CIRCULAR = 2'b01, RESERVED = 2'b10, HYPERBOLIC = 2'b11} coord_e;
  typedef enum logic {ROTATION = 1'b0, VECTORING = 1'b1} op_e;
  localparam int FRAC_BITS  = 16;
  localparam int K_INV_CIRC = 39797;
  localparam int K_INV_HYP  = 79134;
endpackage

// File: rtl/cordic_out_fifo.sv
// cordic_out_fifo: synchronous FIFO whose head output holds the last popped entry while empty
module cordic_out_fifo #(
  parameter int DW    = 99,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? last : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: removes CORDIC gain from x/y, rounds and saturates, and buffers results behind valid/ready
module cordic_gain_comp #(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = cordic_pkg::FRAC_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_mode_op,
  input  logic [1:0]       in_mode_coord,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             out_mode_op,
  output logic [1:0]       out_mode_coord,
  output logic             overflow,
  output logic             busy
);
  import cordic_pkg::*;
  localparam int DW = 3*WIDTH + 3;
  localparam logic signed [WIDTH-1:0]   KC    = WIDTH'(K_INV_CIRC);
  localparam logic signed [WIDTH-1:0]   KH    = WIDTH'(K_INV_HYP);
  localparam logic signed [WIDTH-1:0]   UNITY = WIDTH'(1) << FRAC_BITS;
  localparam logic signed [2*WIDTH-1:0] RND   = (2*WIDTH)'(1) << (FRAC_BITS-1);
  localparam logic signed [2*WIDTH-1:0] MAXV  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MINV  = ~MAXV;
  function automatic logic [WIDTH-1:0] rnd_sat(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH-1:0] r;
    r = (p + RND) >>> FRAC_BITS;
    return r > MAXV ? MAXV[WIDTH-1:0] : r < MINV ? MINV[WIDTH-1:0] : r[WIDTH-1:0];
  endfunction
  logic                      s1_valid, s2_valid, s1_op, s2_op;
  logic [1:0]                s1_coord, s2_coord;
  logic signed [WIDTH-1:0]   s1_x, s1_y, gx, gy, k;
  logic [WIDTH-1:0]          s1_z, s2_z;
  logic signed [2*WIDTH-1:0] s2_px, s2_py;
  logic                      comp, full, empty, pop;
  logic [DW-1:0]             din, dout;
  logic [$clog2(FIFO_DEPTH):0] count;
  // Pass-through fields use a unity gain; round/shift of v*2^FRAC_BITS returns v exactly.
  assign comp = s1_coord == CIRCULAR || s1_coord == HYPERBOLIC;
  assign k    = s1_coord == HYPERBOLIC ? KH : KC;
  assign gx   = comp ? k : UNITY;
  assign gy   = comp && s1_op == ROTATION ? k : UNITY;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      overflow <= overflow | (s2_valid && full && !pop);
    end
    if (in_valid) begin
      s1_x     <= in_x;
      s1_y     <= in_y;
      s1_z     <= in_z;
      s1_op    <= in_mode_op;
      s1_coord <= in_mode_coord;
    end
    s2_px    <= $signed({{WIDTH{s1_x[WIDTH-1]}}, s1_x}) * $signed({{WIDTH{gx[WIDTH-1]}}, gx});
    s2_py    <= $signed({{WIDTH{s1_y[WIDTH-1]}}, s1_y}) * $signed({{WIDTH{gy[WIDTH-1]}}, gy});
    s2_z     <= s1_z;
    s2_op    <= s1_op;
    s2_coord <= s1_coord;
  end
  assign din = {s2_op, s2_coord, rnd_sat(s2_px), rnd_sat(s2_py), s2_z};
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign {out_mode_op, out_mode_coord, out_x, out_y, out_z} = dout;
  assign busy = s1_valid | s2_valid | !empty;
  cordic_out_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp: directed checks of gain compensation, saturation, FIFO flow control and reset
module tb_cordic_gain_comp;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_mode_op = 1'b0, out_ready = 1'b1;
  logic [1:0]  in_mode_coord = 2'b00;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic        out_valid, out_mode_op, overflow, busy;
  logic [1:0]  out_mode_coord;
  logic [31:0] out_x, out_y, out_z;
  int checks = 0, fails = 0;

  cordic_gain_comp dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode_op(in_mode_op),
    .in_mode_coord(in_mode_coord), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_mode_op(out_mode_op), .out_mode_coord(out_mode_coord),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic op, input logic [1:0] coord, input logic [31:0] x, y, z);
    in_valid = 1'b1; in_mode_op = op; in_mode_coord = coord; in_x = x; in_y = y; in_z = z;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({out_valid, overflow, busy, out_x, out_y, out_z, out_mode_op, out_mode_coord} !== 102'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b ovf=%b busy=%b x=%h y=%h z=%h required all zero", out_valid, overflow, busy, out_x, out_y, out_z);
    end
    rst = 1'b0;
  endtask

  task automatic test_circ_rot();
    send(1'b0, 2'b01, 32'd107936, 32'd0, 32'd0);
    tick(1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL circ_latency_early: got v=%b busy=%b required v=0 busy=1", out_valid, busy);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL circ_latency: got out_valid=%b required 1", out_valid);
    end
    checks++;
    if (out_x !== 32'd65545 || out_y !== 32'd0 || out_z !== 32'd0 || out_mode_op !== 1'b0 || out_mode_coord !== 2'b01) begin
      fails++;
      $display("FAIL circ_rot: got x=%0d y=%0d z=%0d op=%b coord=%b required 65545 0 0 0 01", $signed(out_x), $signed(out_y), $signed(out_z), out_mode_op, out_mode_coord);
    end
    tick(1);
  endtask

  task automatic test_circ_vec();
    send(1'b1, 2'b01, 32'd107936, 32'd107936, 32'd5);
    tick(2);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'd65545 || out_y !== 32'd107936 || out_z !== 32'd5 || out_mode_op !== 1'b1) begin
      fails++;
      $display("FAIL circ_vec: got v=%b x=%0d y=%0d z=%0d op=%b required 1 65545 107936 5 1", out_valid, $signed(out_x), $signed(out_y), $signed(out_z), out_mode_op);
    end
    tick(1);
  endtask

  task automatic test_linear();
    send(1'b1, 2'b00, 32'h0003_0000, -32'sd5, 32'd7);
    tick(2);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 32'h0003_0000 || out_y !== 32'hFFFF_FFFB || out_z !== 32'd7 || out_mode_op !== 1'b1 || out_mode_coord !== 2'b00) begin
      fails++;
      $display("FAIL linear: got v=%b x=%h y=%h z=%h op=%b coord=%b required 1 00030000 fffffffb 00000007 1 00", out_valid, out_x, out_y, out_z, out_mode_op, out_mode_coord);
    end
    tick(1);
  endtask

  task automatic test_hyp();
    send(1'b0, 2'b11, -32'sd65536, 32'd65536, 32'd9);
    tick(2);
    checks++;
    if (out_x !== -32'sd79134 || out_y !== 32'd79134 || out_z !== 32'd9 || out_mode_coord !== 2'b11) begin
      fails++;
      $display("FAIL hyp_rot: got x=%0d y=%0d z=%0d coord=%b required -79134 79134 9 11", $signed(out_x), $signed(out_y), $signed(out_z), out_mode_coord);
    end
    tick(1);
    send(1'b0, 2'b11, 32'h7FFF_0000, 32'h8000_0000, 32'd0);
    tick(2);
    checks++;
    if (out_x !== 32'h7FFF_FFFF) begin
      fails++;
      $display("FAIL hyp_sat_pos: got x=%h required 7fffffff", out_x);
    end
    checks++;
    if (out_y !== 32'h8000_0000) begin
      fails++;
      $display("FAIL hyp_sat_neg: got y=%h required 80000000", out_y);
    end
    tick(1);
    send(1'b1, 2'b11, 32'h8000_0000, 32'd1234, 32'd0);
    tick(2);
    checks++;
    if (out_x !== 32'h8000_0000 || out_y !== 32'd1234 || out_mode_op !== 1'b1) begin
      fails++;
      $display("FAIL hyp_vec_min: got x=%h y=%0d op=%b required 80000000 1234 1", out_x, out_y, out_mode_op);
    end
    tick(1);
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(1'b0, 2'b00, 32'(i), 32'(i + 100), 32'(i + 200));
    tick(2);
    checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || out_x !== 32'd1) begin
      fails++;
      $display("FAIL overflow_set: got ovf=%b v=%b x=%0d required 1 1 1", overflow, out_valid, out_x);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_x !== 32'(i) || out_y !== 32'(i + 100) || out_z !== 32'(i + 200)) begin
        fails++;
        $display("FAIL overflow_drain: got v=%b x=%0d y=%0d z=%0d required 1 %0d %0d %0d", out_valid, out_x, out_y, out_z, i, i + 100, i + 200);
      end
      tick(1);
    end
    checks++;
    if (out_valid !== 1'b0 || out_x !== 32'd4 || overflow !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL overflow_empty: got v=%b x=%0d ovf=%b busy=%b required 0 4 1 0", out_valid, out_x, overflow, busy);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 10; i <= 14; i++) send(1'b0, 2'b00, 32'(i), 32'd0, 32'd0);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1 || out_x !== 32'd11) begin
      fails++;
      $display("FAIL full_push_pop: got ovf=%b v=%b x=%0d required 0 1 11", overflow, out_valid, out_x);
    end
    out_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_x !== 32'(i)) begin
        fails++;
        $display("FAIL full_drain: got v=%b x=%0d required 1 %0d", out_valid, out_x, i);
      end
      tick(1);
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_after: got v=%b ovf=%b required 0 0", out_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 2'b01, 32'd20, 32'd0, 32'd0);
    send(1'b0, 2'b01, 32'd21, 32'd0, 32'd0);
    send(1'b0, 2'b01, 32'd22, 32'd0, 32'd0);
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_setup: got v=%b busy=%b required 1 1", out_valid, busy);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out_x !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: got v=%b busy=%b ovf=%b x=%0d required 0 0 0 0", out_valid, busy, overflow, out_x);
    end
    out_ready = 1'b1;
    tick(4);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_x !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_stale: got v=%b busy=%b x=%0d required 0 0 0", out_valid, busy, out_x);
    end
  endtask

  initial begin
    test_reset();
    test_circ_rot();
    test_circ_vec();
    test_linear();
    test_hyp();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
